// File: rtl/clk_gate_ctrl.sv
// Idle-detecting enable controller for a clock-gating cell: withdraws the enable after a run of
// idle cycles, restores it on wake request or force-on, and acks wakes once the clock has settled.
module clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic wake_req_i,
  input  logic force_on_i,
  output logic en_o,
  output logic wake_ack_o,
  output logic gated_o
);

  localparam int unsigned IdleW = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned WakeW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYCLES - 1);
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    StRun,
    StGated,
    StWake
  } state_e;

  state_e           state;
  logic [IdleW-1:0] idle_cnt;
  logic [WakeW-1:0] wake_cnt;
  logic             hold;

  assign hold = busy_i | wake_req_i | force_on_i;

  // en_o and gated_o are updated together with the state so they always mirror it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= StRun;
      idle_cnt   <= '0;
      wake_cnt   <= '0;
      en_o       <= 1'b1;
      gated_o    <= 1'b0;
      wake_ack_o <= 1'b0;
    end else begin
      wake_ack_o <= (state == StRun) & wake_req_i;
      unique case (state)
        StRun: begin
          if (hold) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IdleLast) begin
            state    <= StGated;
            idle_cnt <= '0;
            en_o     <= 1'b0;
            gated_o  <= 1'b1;
          end else if (idle_cnt < IdleLast) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        StGated: begin
          // busy_i is meaningless here: the gated domain is frozen.
          if (wake_req_i | force_on_i) begin
            state    <= StWake;
            wake_cnt <= '0;
            en_o     <= 1'b1;
            gated_o  <= 1'b0;
          end
        end
        StWake: begin
          if (wake_cnt == WakeLast) begin
            state    <= StRun;
            idle_cnt <= '0;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: begin
          state    <= StRun;
          idle_cnt <= '0;
          wake_cnt <= '0;
          en_o     <= 1'b1;
          gated_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: vector table, directed corner sequences, then random stimulus
// against a cycle-level reference model.
module tb_clk_gate_ctrl;

  localparam int unsigned IDLE = 4;
  localparam int unsigned WAKE = 2;

  logic clk = 1'b0;
  logic rst, busy, req, frc;
  logic en, ack, gated;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .busy_i     (busy),
    .wake_req_i (req),
    .force_on_i (frc),
    .en_o       (en),
    .wake_ack_o (ack),
    .gated_o    (gated)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: gated flag, remaining settle cycles, length of the current idle streak.
  bit m_gated     = 1'b0;
  int m_wake_left = 0;
  int m_idle_run  = 0;
  bit m_ack       = 1'b0;

  task automatic model_step(input logic r, input logic b, input logic w, input logic f);
    if (r) begin
      m_gated = 0; m_wake_left = 0; m_idle_run = 0; m_ack = 0;
    end else begin
      m_ack = !m_gated && (m_wake_left == 0) && w;
      if (m_gated) begin
        if (w || f) begin
          m_gated     = 0;
          m_wake_left = WAKE;
        end
      end else if (m_wake_left > 0) begin
        m_wake_left--;
        if (m_wake_left == 0) m_idle_run = 0;
      end else if (b || w || f) begin
        m_idle_run = 0;
      end else begin
        m_idle_run++;
        if (m_idle_run == IDLE) begin
          m_gated    = 1;
          m_idle_run = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Inputs change after the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic r, input logic b, input logic w, input logic f);
    rst = r; busy = b; req = w; frc = f;
    @(posedge clk);
    model_step(r, b, w, f);
    @(negedge clk);
  endtask

  task automatic run_const(input string name, input int n, input logic r, input logic b,
                           input logic w, input logic f, input logic e, input logic a,
                           input logic g);
    for (int i = 0; i < n; i++) begin
      step(r, b, w, f);
      chk($sformatf("%s[%0d].en", name, i), en, e);
      chk($sformatf("%s[%0d].ack", name, i), ack, a);
      chk($sformatf("%s[%0d].gated", name, i), gated, g);
    end
  endtask

  typedef struct packed {
    logic r, b, w, f;  // rst busy wake_req force_on
    logic e, a, g;     // expected en ack gated after the edge
  } vec_t;

  localparam int NVec = 23;
  vec_t tbl[NVec];

  initial begin
    rst = 1'b1; busy = 1'b0; req = 1'b0; frc = 1'b0;
    @(negedge clk);

    //          rbwf_eag
    tbl[0]  = 7'b1000_100;  // reset
    tbl[1]  = 7'b0000_100;
    tbl[2]  = 7'b0000_100;
    tbl[3]  = 7'b0000_100;
    tbl[4]  = 7'b0000_001;  // 4th idle cycle: gated
    tbl[5]  = 7'b0000_001;
    tbl[6]  = 7'b0010_100;  // wake req: WAKE, clock back on
    tbl[7]  = 7'b0010_100;
    tbl[8]  = 7'b0010_100;  // RUN
    tbl[9]  = 7'b0010_110;  // ack
    tbl[10] = 7'b0000_100;  // req dropped: ack falls
    tbl[11] = 7'b0000_100;
    tbl[12] = 7'b0000_100;
    tbl[13] = 7'b0000_001;  // gated 4 idle cycles after release
    tbl[14] = 7'b0001_100;  // force-on pulse
    tbl[15] = 7'b0000_100;
    tbl[16] = 7'b0000_100;  // RUN, idle count 0
    tbl[17] = 7'b0000_100;
    tbl[18] = 7'b0000_100;
    tbl[19] = 7'b0000_100;
    tbl[20] = 7'b0000_001;
    tbl[21] = 7'b0100_001;  // busy ignored while gated
    tbl[22] = 7'b1000_100;  // reset from GATED re-enables at once

    for (int i = 0; i < NVec; i++) begin
      step(tbl[i].r, tbl[i].b, tbl[i].w, tbl[i].f);
      chk($sformatf("vec%0d.en", i), en, tbl[i].e);
      chk($sformatf("vec%0d.ack", i), ack, tbl[i].a);
      chk($sformatf("vec%0d.gated", i), gated, tbl[i].g);
    end

    // Busy pulse after 3 idle cycles restarts the idle count.
    run_const("bp_rst", 1, 1, 0, 0, 0, 1, 0, 0);
    run_const("bp_idle", 3, 0, 0, 0, 0, 1, 0, 0);
    run_const("bp_busy", 1, 0, 1, 0, 0, 1, 0, 0);
    run_const("bp_idle2", 3, 0, 0, 0, 0, 1, 0, 0);
    run_const("bp_gate", 1, 0, 0, 0, 0, 0, 0, 1);

    // Wake request in RUN with idle count 3: no gating, ack next cycle, held while req held.
    run_const("rr_rst", 1, 1, 0, 0, 0, 1, 0, 0);
    run_const("rr_idle", 3, 0, 0, 0, 0, 1, 0, 0);
    run_const("rr_req", 10, 0, 0, 1, 0, 1, 1, 0);
    run_const("rr_drop", 3, 0, 0, 0, 0, 1, 0, 0);
    run_const("rr_gate", 1, 0, 0, 0, 0, 0, 0, 1);

    // Force-on from GATED held for 20 cycles, then released.
    run_const("fo_on", 20, 0, 0, 0, 1, 1, 0, 0);
    run_const("fo_rel", 3, 0, 0, 0, 0, 1, 0, 0);
    run_const("fo_gate", 1, 0, 0, 0, 0, 0, 0, 1);

    // Reset in WAKE: immediate RUN, no ack, idle count restarts.
    run_const("rw_wake", 1, 0, 0, 1, 0, 1, 0, 0);
    run_const("rw_rst", 1, 1, 0, 0, 0, 1, 0, 0);
    run_const("rw_idle", 3, 0, 0, 0, 0, 1, 0, 0);
    run_const("rw_gate", 1, 0, 0, 0, 0, 0, 0, 1);

    // Random traffic against the model; requester follows the 4-phase protocol.
    begin
      logic r, b, w, f;
      int busy_pct;
      w = 1'b0; f = 1'b0; busy_pct = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 50 == 0) begin
          case ($urandom_range(2))
            0: busy_pct = 0;
            1: busy_pct = 10;
            default: busy_pct = 50;
          endcase
        end
        r = ($urandom_range(199) == 0);
        b = ($urandom_range(99) < busy_pct);
        if (!w && !ack && $urandom_range(29) == 0) w = 1'b1;
        else if (w && ack && $urandom_range(1) == 0) w = 1'b0;
        if ($urandom_range(59) == 0) f = ~f;
        step(r, b, w, f);
        chk($sformatf("rnd%0d.en", c), en, !m_gated);
        chk($sformatf("rnd%0d.ack", c), ack, m_ack);
        chk($sformatf("rnd%0d.gated", c), gated, m_gated);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Idle-detecting enable controller that drives the `en_i` input of a clock-gating primitive. It sits directly upstream of the clock gate and runs on the ungated clock. It watches an activity indication from the gated domain and withdraws the enable after a programmable run of idle cycles. It restores the enable on a wake request or a force-on, and acknowledges the requester with a 4-phase handshake once the gated clock has been running for a settling period.

## Interface
- `IDLE_CYCLES`, default 16: consecutive idle cycles required before gating; legal range ≥1.
- `WAKE_CYCLES`, default 2: cycles the enable must be high after ungating before a wake is acknowledged; legal range ≥1.
- `clk_i`, input, 1: ungated clock, the same clock fed to the clock gate's `clk_i`. Single clock domain.
- `rst_i`, input, 1: reset, synchronous, active-high.
- `busy_i`, input, 1: activity from the gated domain; high means not idle. Ignored while gated.
- `wake_req_i`, input, 1: wake request, level, 4-phase handshake.
- `force_on_i`, input, 1: test/debug override; while high, the enable is kept or brought high and gating is inhibited.
- `en_o`, output, 1: registered enable to the clock gate `en_i`.
- `wake_ack_o`, output, 1: registered wake acknowledge.
- `gated_o`, output, 1: registered status, high while in GATED.

## Operation
- Counter `idle_cnt` has width `$clog2(IDLE_CYCLES+1)`. It saturates and never wraps.
- Define `hold = busy_i | wake_req_i | force_on_i`.
- States:
  - RUN: `en_o=1`.
  - GATED: `en_o=0`, `gated_o=1`.
  - WAKE: `en_o=1`, settling.
- In RUN:
  - If `hold`, clear `idle_cnt`.
  - Otherwise, if `idle_cnt == IDLE_CYCLES-1`, go to GATED.
  - Otherwise, increment `idle_cnt`.
- In GATED:
  - If `wake_req_i | force_on_i`, go to WAKE and clear the wake counter.
  - `busy_i` is ignored; the gated domain is frozen.
- In WAKE:
  - Increment the wake counter.
  - After `WAKE_CYCLES` cycles in WAKE, go to RUN with `idle_cnt=0`.
  - `busy_i` and `force_on_i` do not shorten WAKE.
- Outputs are registered: `en_o = (state != GATED)` and `gated_o = (state == GATED)`. No combinational path from inputs to outputs.
- Handshake:
  - `wake_ack_o` is registered from `(state == RUN) & wake_req_i`.
  - The requester holds `wake_req_i` until it sees `wake_ack_o`, then drops it.
  - `wake_ack_o` falls one cycle after `wake_req_i` falls.
  - `wake_ack_o` is never high in GATED or WAKE.
- Simultaneous events:
  - If the idle terminal count coincides with `hold`, `hold` wins: stay in RUN and clear the counter.
  - `wake_req_i` held high in RUN permanently inhibits gating.
- Reset:
  - Values: state RUN, `en_o=1`, `wake_ack_o=0`, `gated_o=0`, all counters 0.
  - Reset asserted in any state forces these values at the next edge. Reset from GATED re-enables the clock one cycle later, with no WAKE delay and no ack.

## Timing
- Gating latency: the last busy cycle is cycle 0 (`busy_i=1`). With cycles 1..`IDLE_CYCLES` idle, state is GATED and `en_o=0` in cycle `IDLE_CYCLES+1`.
- Wake from GATED:
  - `wake_req_i` first sampled high in cycle 0.
  - Cycles 1..`WAKE_CYCLES`: WAKE, `en_o=1`.
  - Cycle `WAKE_CYCLES+1`: RUN.
  - Cycle `WAKE_CYCLES+2`: `wake_ack_o=1`.
- Wake while already in RUN: `wake_ack_o=1` one cycle after `wake_req_i` is first sampled high.
- `force_on_i` from GATED: `en_o=1` one cycle later.
- The downstream gate latches `en_o` on its own clock edge. `en_o` changes only on a `clk_i` rising edge, so it is glitch-free.

## Test plan
Parameters for all scenarios: `IDLE_CYCLES=4`, `WAKE_CYCLES=2`.
- Reset, then hold `busy_i=0` and all other inputs low → `en_o=1` for cycles 1–4 after reset release, `en_o=0` and `gated_o=1` from cycle 5; `wake_ack_o` stays 0.
- Idle for 3 cycles, `busy_i=1` for one cycle, then idle → gating occurs only 4 idle cycles after the busy pulse, not earlier.
- From GATED, raise `wake_req_i` in cycle 0 → `en_o=1` in cycle 1, `wake_ack_o=1` in cycle 4. Drop the request in cycle 5 → ack 0 in cycle 6, gated again 4 idle cycles later.
- In RUN with `idle_cnt=3`, raise `wake_req_i` → no gating; ack next cycle; `en_o` stays 1 throughout.
- From GATED, raise `force_on_i` → `en_o=1` after 1 cycle. Hold it high for 20 cycles → `en_o` never drops and `wake_ack_o=0`. Release it → gated 4 cycles later.
- Assert `rst_i` for one cycle while GATED and again while in WAKE → next cycle `en_o=1`, `gated_o=0`, `wake_ack_o=0`, and the idle count restarts from 0.
